// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issues FP ops to the FPU, stalls for per-class latency and
// arbitrates the float register-file write port between loads and FPU results.
module fpu_issue_ctrl #(
   parameter int LAT_ADDSUB = 3,
   parameter int LAT_MUL    = 4,
   parameter int LAT_DIV    = 16,
   parameter int LAT_SQRT   = 16,
   parameter int LAT_MISC   = 1,
   parameter int CNT_W      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fpu_decoder_en,
   input  logic [4:0] funct5,
   input  logic [4:0] rd,
   input  logic       ld_float_we,
   input  logic [4:0] ld_rd,
   output logic       stall,
   output logic       fpu_start,
   output logic [2:0] fpu_class,
   output logic       busy,
   output logic       fwb_en,
   output logic       fwb_sel,
   output logic [4:0] fwb_rd,
   output logic       iwb_en,
   output logic [4:0] iwb_rd
);
   typedef enum logic [1:0] {IDLE, EXEC, HOLD, WB} state_t;
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, lat;
   logic [4:0] rd_q;
   logic [2:0] cls, cls_q;
   logic int_d, int_q, issue, wbf;
   always_comb begin
      cls = (funct5 == 5'b00000 || funct5 == 5'b00001) ? 3'd0 :
            (funct5 == 5'b00010) ? 3'd1 :
            (funct5 == 5'b00011) ? 3'd2 :
            (funct5 == 5'b01011) ? 3'd3 : 3'd4;
      lat = (cls == 3'd0) ? CNT_W'(LAT_ADDSUB) :
            (cls == 3'd1) ? CNT_W'(LAT_MUL) :
            (cls == 3'd2) ? CNT_W'(LAT_DIV) :
            (cls == 3'd3) ? CNT_W'(LAT_SQRT) : CNT_W'(LAT_MISC);
      int_d = funct5 inside {5'b10100, 5'b11000, 5'b11100};
      issue = fpu_decoder_en & (state == IDLE | state == WB);
   end
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      case (state)
         IDLE: state_nxt = IDLE;
         EXEC: begin
            cnt_nxt = cnt - CNT_W'(1);
            // a load landing in the last EXEC cycle pushes a float result into HOLD
            if (cnt == CNT_W'(1)) state_nxt = (int_q | ~ld_float_we) ? WB : HOLD;
         end
         HOLD: state_nxt = WB;
         WB:   state_nxt = IDLE;
      endcase
      if (issue) begin
         state_nxt = EXEC;
         cnt_nxt = lat;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         rd_q <= '0;
         cls_q <= '0;
         int_q <= 1'b0;
         fpu_start <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         fpu_start <= issue;
         if (issue) begin
            rd_q <= rd;
            cls_q <= cls;
            int_q <= int_d;
         end
      end
   end
   always_comb begin
      wbf = (state == WB) & ~int_q;
      stall = (state == EXEC) | (state == HOLD) | issue;
      busy = state != IDLE;
      fpu_class = cls_q;
      fwb_en = wbf | ld_float_we;
      fwb_sel = wbf;
      fwb_rd = wbf ? rd_q : ld_float_we ? ld_rd : '0;
      iwb_en = (state == WB) & int_q;
      iwb_rd = iwb_en ? rd_q : '0;
   end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed checks of issue timing, stalls, HOLD arbitration,
// integer writeback, async reset abandonment and back-to-back issue.
module tb_fpu_issue_ctrl;
   logic clk = 0, rst = 1, fpu_decoder_en = 0, ld_float_we = 0;
   logic [4:0] funct5 = '0, rd = '0, ld_rd = '0;
   logic stall, fpu_start, busy, fwb_en, fwb_sel, iwb_en;
   logic [2:0] fpu_class;
   logic [4:0] fwb_rd, iwb_rd;
   int checks = 0, failures = 0;
   int n_stall, n_start, wb_cyc, n_wb;

   fpu_issue_ctrl dut (
      .clk(clk), .rst(rst), .fpu_decoder_en(fpu_decoder_en), .funct5(funct5), .rd(rd),
      .ld_float_we(ld_float_we), .ld_rd(ld_rd), .stall(stall), .fpu_start(fpu_start),
      .fpu_class(fpu_class), .busy(busy), .fwb_en(fwb_en), .fwb_sel(fwb_sel),
      .fwb_rd(fwb_rd), .iwb_en(iwb_en), .iwb_rd(iwb_rd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   task automatic issue(input logic [4:0] f, input logic [4:0] r);
      fpu_decoder_en = 1; funct5 = f; rd = r;
   endtask

   initial begin
      #1;
      chk("rst_stall", stall, 0); chk("rst_busy", busy, 0); chk("rst_start", fpu_start, 0);
      chk("rst_fwb", fwb_en, 0); chk("rst_iwb", iwb_en, 0); chk("rst_class", fpu_class, 0);
      nxt(); rst = 0; nxt();

      // fadd.s rd=5
      issue(5'b00000, 5'd5); #1;
      chk("add_c0_stall", stall, 1); chk("add_c0_busy", busy, 0);
      nxt(); fpu_decoder_en = 0; #1;
      chk("add_c1_start", fpu_start, 1); chk("add_c1_class", fpu_class, 0); chk("add_c1_stall", stall, 1);
      nxt(); #1; chk("add_c2_start", fpu_start, 0); chk("add_c2_stall", stall, 1);
      nxt(); #1; chk("add_c3_stall", stall, 1); chk("add_c3_fwb", fwb_en, 0);
      nxt(); #1;
      chk("add_c4_stall", stall, 0); chk("add_c4_fwb_en", fwb_en, 1);
      chk("add_c4_sel", fwb_sel, 1); chk("add_c4_rd", fwb_rd, 5); chk("add_c4_busy", busy, 1);
      nxt(); #1; chk("add_c5_busy", busy, 0); chk("add_c5_fwb", fwb_en, 0);

      // fdiv.s rd=9
      issue(5'b00011, 5'd9);
      n_stall = 0; n_start = 0; wb_cyc = -1;
      for (int c = 0; c < 22; c++) begin
         #1;
         if (stall) n_stall++;
         if (fpu_start) n_start++;
         if (c == 1) chk("div_class", fpu_class, 2);
         if (fwb_en && fwb_sel) begin
            wb_cyc = c;
            chk("div_wb_rd", fwb_rd, 9);
         end
         nxt(); fpu_decoder_en = 0;
      end
      chk("div_stall_cycles", n_stall, 17); chk("div_starts", n_start, 1); chk("div_wb_cycle", wb_cyc, 17);

      // fmul.s rd=3 with load in last EXEC cycle
      issue(5'b00010, 5'd3); nxt(); fpu_decoder_en = 0;
      #1; chk("mul_class", fpu_class, 1);
      nxt(); nxt(); nxt();
      ld_float_we = 1; ld_rd = 5'd7; #1;
      chk("mul_c4_fwb_en", fwb_en, 1); chk("mul_c4_sel", fwb_sel, 0); chk("mul_c4_rd", fwb_rd, 7);
      nxt(); ld_float_we = 0; #1;
      chk("mul_hold_fwb", fwb_en, 0); chk("mul_hold_stall", stall, 1); chk("mul_hold_busy", busy, 1);
      nxt(); #1;
      chk("mul_wb_en", fwb_en, 1); chk("mul_wb_sel", fwb_sel, 1); chk("mul_wb_rd", fwb_rd, 3);
      chk("mul_wb_stall", stall, 0);
      nxt();

      // feq.s rd=12, load concurrent with WB
      issue(5'b10100, 5'd12); nxt(); fpu_decoder_en = 0;
      #1; chk("feq_class", fpu_class, 4); chk("feq_c1_stall", stall, 1);
      nxt(); ld_float_we = 1; ld_rd = 5'd4; #1;
      chk("feq_iwb_en", iwb_en, 1); chk("feq_iwb_rd", iwb_rd, 12);
      chk("feq_ld_en", fwb_en, 1); chk("feq_ld_sel", fwb_sel, 0); chk("feq_ld_rd", fwb_rd, 4);
      chk("feq_wb_stall", stall, 0);
      nxt(); ld_float_we = 0; #1;
      chk("feq_c3_busy", busy, 0); chk("feq_c3_iwb", iwb_en, 0);

      // fsqrt.s rd=2 abandoned by reset at cycle 6
      issue(5'b01011, 5'd2); nxt(); fpu_decoder_en = 0;
      for (int c = 1; c < 6; c++) nxt();
      #1; chk("sqrt_c6_busy", busy, 1); chk("sqrt_c6_class", fpu_class, 3);
      rst = 1; #1;
      chk("sqrt_rst_stall", stall, 0); chk("sqrt_rst_busy", busy, 0); chk("sqrt_rst_start", fpu_start, 0);
      chk("sqrt_rst_class", fpu_class, 0); chk("sqrt_rst_fwb", fwb_en, 0); chk("sqrt_rst_iwb", iwb_en, 0);
      nxt(); rst = 0;
      n_wb = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (fwb_en || iwb_en || busy) n_wb++;
         nxt();
      end
      chk("sqrt_no_wb", n_wb, 0);
      issue(5'b00001, 5'd6); #1; chk("post_rst_stall", stall, 1);
      nxt(); fpu_decoder_en = 0; #1; chk("post_rst_start", fpu_start, 1);
      nxt(); nxt(); nxt(); #1;
      chk("post_rst_fwb_en", fwb_en, 1); chk("post_rst_rd", fwb_rd, 6);
      nxt();

      // back-to-back fadd.s rd=1 then fmul.s rd=8
      issue(5'b00000, 5'd1); nxt(); fpu_decoder_en = 0;
      nxt(); nxt(); nxt();
      issue(5'b00010, 5'd8); #1;
      chk("b2b_wb_en", fwb_en, 1); chk("b2b_wb_rd", fwb_rd, 1); chk("b2b_wb_stall", stall, 1);
      nxt(); fpu_decoder_en = 0; #1;
      chk("b2b_start", fpu_start, 1); chk("b2b_class", fpu_class, 1); chk("b2b_busy", busy, 1);
      nxt(); nxt(); nxt(); #1; chk("b2b_c8_stall", stall, 1); chk("b2b_c8_fwb", fwb_en, 0);
      nxt(); #1;
      chk("b2b_wb2_en", fwb_en, 1); chk("b2b_wb2_rd", fwb_rd, 8); chk("b2b_wb2_stall", stall, 0);
      nxt(); #1; chk("b2b_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
